// File: rtl/fifo_push_arbiter_if.sv
// Push-side bus between requesters/consumer and the FIFO push arbiter.
// The master drives requests and pops; the slave (arbiter) returns grants, push data and occupancy.
interface fifo_push_arbiter_if #(
    parameter int D_WIDTH = 6,
    parameter int N_REQ   = 4,
    parameter int DEPTH   = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*D_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         gnt;
    logic                     push;
    logic [D_WIDTH-1:0]       up_data;
    logic                     pop;
    logic [LW-1:0]            level;
    logic                     full;
    logic                     empty;

    modport master (
        output req, req_data, pop,
        input  gnt, push, up_data, level, full, empty
    );

    modport slave (
        input  req, req_data, pop,
        output gnt, push, up_data, level, full, empty
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N_REQ requesters.
// Occupancy is tracked from our own pushes plus snooped consumer pops; grants stop at DEPTH.
module fifo_push_arbiter #(
    parameter int D_WIDTH = 6,
    parameter int N_REQ   = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_push_arbiter_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               push_q, push_d;
    logic [D_WIDTH-1:0] up_data_q, up_data_d;
    logic [LW-1:0]      fifo_cnt_q, fifo_cnt_d;

    logic [LW-1:0]      level_w;
    logic               full_w;
    logic [N_REQ-1:0]   gnt_w;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      scan_idx;
    logic               found;
    logic               acc;
    logic               eff_pop;

    // Index base+offs modulo N_REQ; both operands are below N_REQ so one wrap suffices.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // The in-flight push already counts against capacity, so level never overshoots DEPTH.
    assign level_w = fifo_cnt_q + LW'(push_q);
    assign full_w  = (level_w == LW'(DEPTH));

    always_comb begin
        gnt_idx  = '0;
        scan_idx = '0;
        found    = 1'b0;
        gnt_w    = '0;
        if (rst && !full_w) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan_idx = rr_index(ptr_q, k);
                if (!found && bus.req[scan_idx]) begin
                    found   = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        if (found) gnt_w = N_REQ'(1) << gnt_idx;
    end

    assign acc = |(bus.req & gnt_w);

    // The FIFO ignores a pop only when it is empty and nothing is landing this edge.
    assign eff_pop = bus.pop && ((fifo_cnt_q != '0) || push_q);

    always_comb begin
        ptr_d      = acc ? rr_index(gnt_idx, 1) : ptr_q;
        push_d     = acc;
        up_data_d  = acc ? bus.req_data[int'(gnt_idx)*D_WIDTH +: D_WIDTH] : up_data_q;
        fifo_cnt_d = fifo_cnt_q + LW'(push_q) - LW'(eff_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            push_q     <= 1'b0;
            up_data_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            push_q     <= push_d;
            up_data_q  <= up_data_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign bus.gnt     = gnt_w;
    assign bus.push    = push_q;
    assign bus.up_data = up_data_q;
    assign bus.level   = level_w;
    assign bus.full    = full_w;
    assign bus.empty   = (level_w == '0);
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: hand-computed grant order, push data and occupancy.
module tb_fifo_push_arbiter;
    localparam int D_WIDTH = 6;
    localparam int N_REQ   = 4;
    localparam int DEPTH   = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fifo_push_arbiter_if #(.D_WIDTH(D_WIDTH), .N_REQ(N_REQ), .DEPTH(DEPTH)) bus ();

    fifo_push_arbiter #(.D_WIDTH(D_WIDTH), .N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [5:0] d0, input logic [5:0] d1,
                            input logic [5:0] d2, input logic [5:0] d3);
        bus.req_data = {d3, d2, d1, d0};
    endtask

    logic [5:0] dat [4];

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.pop = 1'b0;

        // Reset state, with requests present to show grants are gated
        #1 rst = 1'b0;
        bus.req = 4'b1111;
        #2;
        check("rst_push",  32'(bus.push),    32'h0);
        check("rst_data",  32'(bus.up_data), 32'h0);
        check("rst_level", 32'(bus.level),   32'h0);
        check("rst_empty", 32'(bus.empty),   32'h1);
        check("rst_full",  32'(bus.full),    32'h0);
        check("rst_gnt",   32'(bus.gnt),     32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.req = '0;

        // Single requester 2 with three back-to-back words
        dat[0] = 6'h15; dat[1] = 6'h2A; dat[2] = 6'h3F;
        bus.req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_data(6'h00, 6'h00, dat[k], 6'h00);
            #1;
            check("single_gnt", 32'(bus.gnt), 32'h4);
            step();
            check("single_push",  32'(bus.push),    32'h1);
            check("single_data",  32'(bus.up_data), 32'(dat[k]));
            check("single_level", 32'(bus.level),   32'(k + 1));
        end
        bus.req = '0;
        step();
        check("single_idle_push", 32'(bus.push),    32'h0);
        check("single_hold_data", 32'(bus.up_data), 32'h3F);
        check("single_hold_lvl",  32'(bus.level),   32'h3);

        // Drain three words, then one extra pop on empty
        bus.pop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("drain_level", 32'(bus.level), 32'(2 - k));
        end
        step();
        check("pop_empty_level", 32'(bus.level), 32'h0);
        check("pop_empty_empty", 32'(bus.empty), 32'h1);
        bus.pop = 1'b0;

        // One accept (ptr is 3, so req[0] wins), pop during its push cycle
        bus.req = 4'b0001;
        set_data(6'h01, 6'h00, 6'h00, 6'h00);
        #1;
        check("pt_gnt", 32'(bus.gnt), 32'h1);
        step();
        check("pt_level1", 32'(bus.level), 32'h1);
        bus.req = '0;
        bus.pop = 1'b1;
        step();
        check("pt_level0", 32'(bus.level), 32'h0);
        check("pt_empty",  32'(bus.empty), 32'h1);
        bus.pop = 1'b0;

        // Reset mid-operation: ptr is 1, three accepts go to 1, 2, 3
        bus.req = 4'b1111;
        set_data(6'h05, 6'h0A, 6'h14, 6'h28);
        step();
        step();
        step();
        check("mid_push",  32'(bus.push),  32'h1);
        check("mid_level", 32'(bus.level), 32'h3);
        check("mid_data",  32'(bus.up_data), 32'h28);
        rst = 1'b0;
        #1;
        check("arst_push",  32'(bus.push),    32'h0);
        check("arst_data",  32'(bus.up_data), 32'h0);
        check("arst_level", 32'(bus.level),   32'h0);
        check("arst_gnt",   32'(bus.gnt),     32'h0);
        check("arst_empty", 32'(bus.empty),   32'h1);
        step();
        rst = 1'b1;

        // All four requesting from ptr 0 with no pops until full
        dat[0] = 6'h05; dat[1] = 6'h0A; dat[2] = 6'h14; dat[3] = 6'h28;
        set_data(dat[0], dat[1], dat[2], dat[3]);
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_gnt",   32'(bus.gnt),   32'(1 << (k % 4)));
            check("rr_level", 32'(bus.level), 32'(k));
            step();
            check("rr_data", 32'(bus.up_data), 32'(dat[k % 4]));
        end
        check("full_level", 32'(bus.level), 32'h8);
        check("full_flag",  32'(bus.full),  32'h1);
        check("full_gnt",   32'(bus.gnt),   32'h0);

        // Pop while full: no pop-through grant, then gnt[0] after level drops
        bus.pop = 1'b1;
        #1;
        check("full_pop_gnt", 32'(bus.gnt), 32'h0);
        step();
        bus.pop = 1'b0;
        #1;
        check("refill_level", 32'(bus.level), 32'h7);
        check("refill_full",  32'(bus.full),  32'h0);
        check("refill_gnt",   32'(bus.gnt),   32'h1);
        step();
        check("refill_push", 32'(bus.push),    32'h1);
        check("refill_data", 32'(bus.up_data), 32'h05);
        check("refill_lvl8", 32'(bus.level),   32'h8);
        check("refill_gnt0", 32'(bus.gnt),     32'h0);

        // Drain fully; ptr is now 1
        bus.req = '0;
        bus.pop = 1'b1;
        for (int k = 0; k < 8; k++) step();
        bus.pop = 1'b0;
        #1;
        check("drain_all_level", 32'(bus.level), 32'h0);
        check("drain_all_empty", 32'(bus.empty), 32'h1);

        // Sparse wrap: only requesters 1 and 3
        dat[1] = 6'h11; dat[3] = 6'h33;
        set_data(6'h00, dat[1], 6'h00, dat[3]);
        bus.req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("sparse_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h2 : 32'h8);
            step();
            check("sparse_data",  32'(bus.up_data), (k % 2 == 0) ? 32'h11 : 32'h33);
            check("sparse_level", 32'(bus.level),   32'(k + 1));
        end

        // Simultaneous accept and effective pop keep level steady
        bus.pop = 1'b1;
        #1;
        check("simul_gnt", 32'(bus.gnt), 32'h2);
        step();
        check("simul_level", 32'(bus.level), 32'h4);
        check("simul_push",  32'(bus.push),  32'h1);
        bus.pop = 1'b0;
        bus.req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin scheduler that shares the push port of a single D_WIDTH-wide FIFO among N_REQ requesters. It tracks FIFO occupancy by counting its own pushes and snooping the consumer's pops, and issues grants only while space remains. It sits directly in front of the FIFO's up_data/push inputs; the consumer drives pop to both the FIFO and this block.

## Interface

- D_WIDTH, 6: data word width.
- N_REQ, 4: number of requesters (≥2).
- DEPTH, 8: FIFO capacity in words; LW = clog2(DEPTH+1).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  N_REQ  per-requester request; held until granted.
- req_data  in  N_REQ*D_WIDTH  per-requester word; slice i = bits [i*D_WIDTH +: D_WIDTH].
- gnt  out  N_REQ  one-hot grant, combinational from req and registered state.
- push  out  1  registered push to FIFO.
- up_data  out  D_WIDTH  registered word to FIFO.
- pop  in  1  consumer pop, same signal the FIFO sees.
- level  out  LW  words in FIFO plus in-flight push.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.

## Operation

- Accept for requester i = req[i] && gnt[i] at a rising edge.
- gnt:
  - At most one bit set.
  - All zero when level == DEPTH or during reset.
  - Otherwise set for the first requesting index scanning from ptr upward, mod N_REQ.
- ptr: registered round-robin pointer, reset 0. On accept from i, ptr <= (i+1) mod N_REQ; unchanged otherwise.
- On accept from i, the next cycle has push = 1 and up_data = slice i; with no accept, push = 0 and up_data holds its last value.
- Internal fifo_cnt tracks words actually stored in the FIFO. The FIFO handles push before pop at the same edge and ignores pop when empty, so:
  - eff_pop = pop && (fifo_cnt != 0 || push).
  - fifo_cnt <= fifo_cnt + push − eff_pop.
- level = fifo_cnt + push, combinational from registers.
- Grants are never issued on a pop-through basis: a full FIFO blocks grants even if pop is high that cycle.
- A requester with back-to-back words keeps req high and presents the next word in the cycle after its accept. It is granted again only after other pending requesters have been served.
- Reset (rst = 0, asynchronous): push = 0, up_data = 0, fifo_cnt = 0, ptr = 0, so level = 0, empty = 1, full = 0, gnt = 0. Deassertion is synchronised to clk by the system; the first grant is possible in the first cycle after release. Reset mid-transfer discards the in-flight push.

## Timing

- Grant latency 0 cycles: gnt responds combinationally to req within the same cycle.
- Accept-to-push latency 1 cycle. Push is a single-cycle pulse per accepted word; max one word per cycle.
- level, full and empty update 1 cycle after an accept, or 1 cycle after an effective pop.
- Simultaneous accept and effective pop leave level unchanged.
- Pop with fifo_cnt = 0 and push = 0 is ignored; level stays 0.
- Sustained throughput is 1 word/cycle while level < DEPTH. When level reaches DEPTH, gnt drops in that same cycle.

## Test plan

- Reset mid-operation: after 3 accepts with push high, drive rst = 0 -> push, up_data, level and gnt go to 0 immediately, with no clock edge required; empty = 1.
- Single requester: req[2] = 1 for 3 cycles with data 0x15, 0x2A, 0x3F -> gnt[2] = 1 each cycle; push pulses 1 cycle later carrying 0x15, 0x2A, 0x3F; level goes 1, 2, 3.
- All 4 requesting continuously, no pop -> grant order 0, 1, 2, 3, 0, 1, 2, 3; after 8 accepts level = 8, full = 1, gnt = 0.
- From full with last grant to 3 and all requesting, pop for 1 cycle -> level = 7 one cycle later; gnt[0] the following cycle; level returns to 8.
- Pop on empty: level = 0, pop = 1 -> level stays 0. Then accept one word and pop in the push cycle -> that pop is effective and level returns to 0.
- Sparse wrap: only req[1] and req[3] high continuously -> grant order 1, 3, 1, 3; ptr wraps 2 -> 0 -> 2 correctly.
